// File: rtl/raifes_gpio_in_cond.sv
`default_nettype none
// ============================================================================
//  Module   : raifes_gpio_in_cond
//  Purpose  : GPIO input conditioning. Pad inputs are synchronised into clk,
//             debounced per bit, and presented as a clean level together with
//             one-cycle rise/fall pulses and sticky event-pending flags.
//  Revision : 1.0 - initial release
// ============================================================================
module raifes_gpio_in_cond #(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] pad_i,
    input  logic             debounce_bypass,
    input  logic [WIDTH-1:0] event_clr,
    output logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic [WIDTH-1:0] event_pend
);

    // Counter width: $clog2 of the debounce length, never narrower than 1.
    localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

    // Debounce state is implied by the counter: zero means the level is settled.
    localparam logic [0:0] c_ST_STABLE = 1'b0;
    localparam logic [0:0] c_ST_COUNT  = 1'b1;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] r_gpio;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_pend;
    logic [WIDTH-1:0] w_gpio_nxt;
    logic [WIDTH-1:0] w_rise_nxt;
    logic [WIDTH-1:0] w_fall_nxt;
    logic [WIDTH-1:0] w_pend_nxt;

    // Plain flop chain per bit; nothing between stages so metastability can settle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
        end else begin
            r_sync[0] <= pad_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

    generate
        for (genvar n = 0; n < WIDTH; n++) begin : g_bit
            if (DEBOUNCE_CYCLES == 1) begin : g_direct
                // A single cycle of persistence is just the synchronised level.
                assign w_gpio_nxt[n] = w_sync[n];
            end else begin : g_count
                logic [CNT_W-1:0] r_cnt;
                logic [CNT_W-1:0] w_cnt_nxt;
                logic             w_lvl_nxt;
                logic [0:0]       w_state;

                assign w_state = (r_cnt != '0) ? c_ST_COUNT : c_ST_STABLE;

                // Counter register: the debounce state lives entirely in r_cnt.
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end

                // Next-state: count consecutive mismatches, accept on the last one,
                // drop back to stable as soon as the input agrees again.
                always_comb begin
                    w_cnt_nxt = '0;
                    w_lvl_nxt = r_gpio[n];
                    if (debounce_bypass) begin
                        w_lvl_nxt = w_sync[n];
                    end else if (w_sync[n] != r_gpio[n]) begin
                        case (w_state)
                            c_ST_STABLE: begin
                                w_cnt_nxt = c_CNT_ONE;
                            end
                            c_ST_COUNT: begin
                                if (r_cnt == c_CNT_LAST) begin
                                    w_lvl_nxt = w_sync[n];
                                end else begin
                                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                                end
                            end
                            default: begin
                                w_cnt_nxt = '0;
                            end
                        endcase
                    end
                end

                assign w_gpio_nxt[n] = w_lvl_nxt;
            end
        end
    endgenerate

    // Output logic: edge pulses line up with the level change; set beats clear.
    always_comb begin
        w_rise_nxt = w_gpio_nxt & ~r_gpio;
        w_fall_nxt = ~w_gpio_nxt & r_gpio;
        w_pend_nxt = (r_pend & ~event_clr) | r_rise | r_fall;
    end

    // Output registers for level, edge pulses and pending flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_gpio <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_pend <= '0;
        end else begin
            r_gpio <= w_gpio_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_pend <= w_pend_nxt;
        end
    end

    assign gpio_i     = r_gpio;
    assign rise_o     = r_rise;
    assign fall_o     = r_fall;
    assign event_pend = r_pend;

endmodule
`default_nettype wire
